// File: rtl/io_pkg.sv
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared constants for the IO display peripheral. It holds the IO
//            register addresses, the all-off segment pattern and the
//            hex-to-seven-segment lookup table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg7_t;     // active-low {g,f,e,d,c,b,a}

  localparam logic [7:0] IO_LED_ADDR    = 8'h60;
  localparam logic [7:0] IO_SEG_LO_ADDR = 8'h70;
  localparam logic [7:0] IO_SEG_HI_ADDR = 8'h74;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low segment patterns for the hex digits 0..F, indexed by nibble.
  localparam seg7_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage : io_pkg

`default_nettype wire

// File: rtl/seg_hex_decoder.sv
// ============================================================================
// Module   : seg_hex_decoder
// Purpose  : Combinational decoder from a hex nibble to an active-low
//            seven-segment pattern.
// Ports    : i_nibble - 4-bit hex value
//            o_seg    - active-low segments {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_hex_decoder
  import io_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule : seg_hex_decoder

`default_nettype wire

// File: rtl/io_display_ctrl.sv
// ============================================================================
// Module   : io_display_ctrl
// Purpose  : Output-side IO peripheral. Latches an LED register and a 32-bit
//            seven-segment value from CPU IO stores, drives a 16-bit LED bank
//            and time-multiplexes an 8-digit common-anode hex display.
// Ports    : clk      - CPU (divided) clock
//            reset    - asynchronous active-high reset
//            io_we    - IO write strobe
//            addr     - low byte of the IO address
//            io_wdata - store data halfword
//            led_out  - LED drive, 1 = lit
//            seg_an   - digit anodes, active-low, bit 0 = rightmost digit
//            seg_cat  - cathodes {dp,g,f,e,d,c,b,a}, active-low
// Options  : LEAD_ZERO_BLANK_EN - when defined, digits above the most
//            significant nonzero nibble are blanked (digit 0 always shown).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_display_ctrl
  import io_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_we,
  input  logic [7:0]  addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int                CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_L  = CNT_W'(DEAD_CYCLES);

  logic [15:0]      r_led;
  logic [31:0]      r_seg_val;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_seg_an;
  logic [7:0]       r_seg_cat;

  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic             w_dead;
  logic             w_blank_digit;
  logic [7:0]       w_an_next;
  logic [7:0]       w_cat_next;

  // --------------------------------------------------------------------------
  // Register write decode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led     <= 16'h0000;
      r_seg_val <= 32'h0000_0000;
    end else if (io_we) begin
      case (addr)
        IO_LED_ADDR:    r_led            <= io_wdata;
        IO_SEG_LO_ADDR: r_seg_val[15:0]  <= io_wdata;
        IO_SEG_HI_ADDR: r_seg_val[31:16] <= io_wdata;
        default: ;
      endcase
    end
  end

  assign led_out = r_led;

  // --------------------------------------------------------------------------
  // Slot counter and digit index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit decode
  // --------------------------------------------------------------------------
  assign w_nibble = r_seg_val[{r_idx, 2'b00} +: 4];

  seg_hex_decoder u_hex_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  assign w_dead = (r_cnt < DEAD_L);

`ifdef LEAD_ZERO_BLANK_EN
  // Position of the most significant nonzero nibble; stays 0 for an all-zero
  // value so digit 0 is always lit.
  logic [2:0] w_top;

  always_comb begin
    w_top = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_seg_val[4*i +: 4] != 4'h0) begin
        w_top = 3'(i);
      end
    end
  end

  assign w_blank_digit = (r_idx > w_top);
`else
  assign w_blank_digit = 1'b0;
`endif

  always_comb begin
    w_an_next  = SEG_OFF;
    w_cat_next = SEG_OFF;
    if (!w_dead && !w_blank_digit) begin
      w_an_next  = ~(8'b1 << r_idx);
      w_cat_next = {1'b1, w_seg};   // decimal point kept off
    end
  end

  // Display outputs are registered from the pre-edge scan position and value,
  // so the display lags the scan state by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_an  <= SEG_OFF;
      r_seg_cat <= SEG_OFF;
    end else begin
      r_seg_an  <= w_an_next;
      r_seg_cat <= w_cat_next;
    end
  end

  assign seg_an  = r_seg_an;
  assign seg_cat = r_seg_cat;

endmodule : io_display_ctrl

`default_nettype wire
